data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Byte-addressed, parametrised data memory for the RISC-V core's load/store path.
- Replaces the flat word-wide register array with:
  - RISC-V sized accesses (byte/half/word/double) with byte-lane writes.
  - Load sign/zero extension.
  - Misalignment and range error reporting.
  - A post-reset zero-clear sequence.
- Sits between the execute stage's address/data outputs and the writeback mux.

Parameters:
- DEPTH, 32, number of XLEN-wide words; power of two, ≥2.
- XLEN, 64, word width in bits; 32 or 64.
- ADDR_W, $clog2(DEPTH)+$clog2(XLEN/8), byte-address width; derived, not overridable.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  access request this cycle.
- req_ready  out  1  block accepts requests (0 during clear).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 size/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  response valid, exactly one cycle after accept.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, unsupported size, or out-of-range access.

Behaviour:
- **Reset.**
  - rst_n=0 sampled at posedge: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - FSM enters CLEAR with clr_idx=0.
  - Array contents are not reset directly.
- **FSM states.**
  - CLEAR:
    - Each cycle writes 0 to word clr_idx, then increments it.
    - After writing word DEPTH-1, go to RUN. CLEAR lasts exactly DEPTH cycles.
    - req_ready=0 throughout; requests are ignored.
  - RUN:
    - req_ready=1.
    - Stays in RUN until rst_n=0.
- **Reset mid-operation.**
  - rst_n=0 in any state, including mid-CLEAR, restarts CLEAR at index 0.
  - Any in-flight response is dropped: rsp_valid=0 on the next cycle.
- **Accept.** A request is accepted when req_valid & req_ready at a posedge.
- **Size decode (funct3).**
  - 000 = B (signed), 001 = H (signed), 010 = W (signed), 011 = D.
  - 100 = BU, 101 = HU, 110 = WU.
  - 111 is always an error.
  - 011 and 110 are errors when XLEN=32.
  - Stores accept only 000–011 (011 only if XLEN=64); funct3[2]=1 on a store is an error.
- **Errors.**
  - Misaligned: addr mod size ≠ 0, size in bytes 1/2/4/8.
  - Error precedence: unsupported size > misaligned; range error cannot occur, since ADDR_W covers exactly DEPTH words.
  - Erroring request: no array write, rsp_err=1, rsp_rdata=0.
- **Byte layout.**
  - Word index = addr[ADDR_W-1:$clog2(XLEN/8)]; byte offset = low bits.
  - Little-endian: byte k of a word occupies value bits 8k..8k+7.
- **Store.**
  - Write occurs at the accepting posedge; only bytes offset..offset+size-1 change.
  - Source is req_wdata bytes 0..size-1.
  - Next cycle: rsp_valid=1, rsp_err=0, rsp_rdata=0.
- **Load.**
  - Array read at the accepting posedge.
  - Next cycle: rsp_valid=1, with rsp_rdata = selected bytes shifted to bit 0.
  - Extension: sign-extended for B/H/W, zero-extended for BU/HU/WU.
- **Latency and throughput.**
  - Latency is exactly 1 cycle for every accepted request.
  - One request per cycle sustained; no backpressure on the response side.
  - rsp_valid=0 in any cycle following a non-accept.
- **Ordering.** A load accepted the cycle after a store to the same bytes returns the new data. Stores are single-edge, so there is no read/write hazard.
- All outputs are registered.

Decomposition:
- Shared package mem_pkg:
  - funct3 encodings: F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - State enum: CLEAR, RUN.
  - Function size_bytes(funct3) returning 1/2/4/8.
- One natural sub-module, load_align:
  - Combinational.
  - Takes word, offset and funct3; returns the extended XLEN result.
  - Reused later by the cache.

Test Plan:
1. **Reset/clear.** Hold rst_n=0 for 2 cycles, release. Then:
   - req_ready=0 for exactly DEPTH=32 cycles, then 1.
   - LD from every address 0x00..0xF8 returns 0.
   - Repeat with rst_n pulsed low at clear cycle 10; a full 32 cycles must follow.
2. **Full-word round trip.**
   - SD 0x0123456789ABCDEF @0x10, then LD @0x10 → rsp_rdata 0x0123456789ABCDEF, rsp_err=0, exactly 1 cycle after accept.
3. **Sub-word loads and extension** (memory @0x10 = 0x0123456789ABCDEF):
   - LB @0x10 → 0xFFFFFFFFFFFFFFEF; LBU @0x10 → 0xEF.
   - LH @0x12 → 0xFFFFFFFFFFFF89AB; LW @0x14 → 0x0000000001234567; LWU @0x10 → 0x89ABCDEF.
4. **Byte-lane store.**
   - SB 0x55 @0x13, then LD @0x10 → 0x0123456755ABCDEF; other words unchanged.
5. **Error cases.**
   - LH @0x11, SW @0x22, SD @0x0C, funct3=111 → rsp_err=1, rsp_rdata=0.
   - Follow-up LD shows memory unchanged.
   - With XLEN=32: LD/LWU → rsp_err=1.
6. **Back-to-back traffic.**
   - Alternate SW/LW to the same address over 8 consecutive cycles (req_valid held 1).
   - Every response is 1 cycle late, no bubbles, and each load sees the immediately preceding store.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the data memory and its load aligner:
//                RISC-V funct3 size codes, controller state encoding and an
//                access-size helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // RISC-V load/store funct3 codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Controller state: zero-clear after reset, then normal operation
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Access size in bytes; only the low two funct3 bits encode the size
    function automatic logic [3:0] size_bytes(input logic [2:0] i_funct3);
        case (i_funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/data_memory_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_if
//  Description : Request/response bundle between the execute stage (master)
//                and the data memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_if #(
    parameter int DEPTH = 32,
    parameter int XLEN  = 64
);
    localparam int ADDR_W = $clog2(DEPTH) + $clog2(XLEN / 8);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface : data_memory_if
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load aligner. Selects the addressed bytes of a
//                word, shifts them to bit 0 and sign/zero extends to XLEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  wire logic [XLEN-1:0]              i_word,
    input  wire logic [$clog2(XLEN/8)-1:0]    i_off,
    input  wire logic [2:0]                   i_funct3,
    output logic      [XLEN-1:0]              o_data
);

    logic [XLEN-1:0] w_sh;

    // Shift the addressed byte to bit 0, then fill the upper bits by sign
    // or with zeros; filling the full width first avoids zero-width
    // replications when XLEN=32.
    always_comb begin
        w_sh   = i_word >> {i_off, 3'b000};
        o_data = '0;
        case (i_funct3)
            F3_B: begin
                o_data       = {XLEN{w_sh[7]}};
                o_data[7:0]  = w_sh[7:0];
            end
            F3_H: begin
                o_data       = {XLEN{w_sh[15]}};
                o_data[15:0] = w_sh[15:0];
            end
            F3_W: begin
                o_data       = {XLEN{w_sh[31]}};
                o_data[31:0] = w_sh[31:0];
            end
            F3_D:  o_data        = w_sh;
            F3_BU: o_data[7:0]   = w_sh[7:0];
            F3_HU: o_data[15:0]  = w_sh[15:0];
            F3_WU: o_data[31:0]  = w_sh[31:0];
            default: o_data = '0;
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : Byte-addressed data memory for the load/store path. Sized
//                RISC-V accesses with byte-lane writes, load extension,
//                misalignment/size error reporting and a post-reset
//                zero-clear sweep. One-cycle latency, one request per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory
    import mem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int XLEN  = 64
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    data_memory_if.slave  bus
);

    localparam int NB     = XLEN / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int ADDR_W = IDX_W + OFF_W;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DEPTH - 1);

    // Storage and control state
    logic [XLEN-1:0]  r_mem [DEPTH];
    state_t           r_state;
    logic [IDX_W-1:0] r_clr_idx;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic [XLEN-1:0]  r_rsp_rdata;

    // Request decode
    logic [IDX_W-1:0] w_idx;
    logic [OFF_W-1:0] w_off;
    logic [3:0]       w_size;
    logic [3:0]       w_size_m1;
    logic             w_bad_size;
    logic             w_misalign;
    logic             w_err;
    logic             w_accept;
    logic             w_store_go;
    logic [NB-1:0]    w_base;
    logic [NB-1:0]    w_be;
    logic [XLEN-1:0]  w_wdata_sh;
    logic [XLEN-1:0]  w_rd_word;
    logic [XLEN-1:0]  w_load;

    assign w_idx      = bus.req_addr[ADDR_W-1:OFF_W];
    assign w_off      = bus.req_addr[OFF_W-1:0];
    assign w_size     = size_bytes(bus.req_funct3);
    assign w_size_m1  = w_size - 4'd1;
    assign w_accept   = bus.req_valid && (r_state == RUN);
    assign w_err      = w_bad_size || w_misalign;
    assign w_store_go = w_accept && bus.req_we && !w_err;
    assign w_wdata_sh = bus.req_wdata << {w_off, 3'b000};
    assign w_rd_word  = r_mem[w_idx];

    // Unsupported size: 111 always; D/WU only exist on RV64; stores have no
    // unsigned variants. This outranks misalignment.
    always_comb begin
        w_bad_size = 1'b0;
        if (bus.req_funct3 == 3'b111) begin
            w_bad_size = 1'b1;
        end
        if ((XLEN == 32) && ((bus.req_funct3 == F3_D) || (bus.req_funct3 == F3_WU))) begin
            w_bad_size = 1'b1;
        end
        if (bus.req_we && bus.req_funct3[2]) begin
            w_bad_size = 1'b1;
        end
    end

    // Misaligned when any offset bit below the access size is set; the size
    // mask never exceeds the offset width for a legal size.
    always_comb begin
        w_misalign = |(w_off & w_size_m1[OFF_W-1:0]);
    end

    // Byte-enable: size contiguous lanes starting at the byte offset
    always_comb begin
        w_base = '0;
        for (int b = 0; b < NB; b++) begin
            if (b < int'(w_size)) begin
                w_base[b] = 1'b1;
            end
        end
        w_be = w_base << w_off;
    end

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .i_word   (w_rd_word),
        .i_off    (w_off),
        .i_funct3 (bus.req_funct3),
        .o_data   (w_load)
    );

    // Clear sweep and controller state; responses are registered one cycle
    // after accept and dropped on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= CLEAR;
            r_clr_idx   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == c_LAST_IDX) begin
                        r_state <= RUN;
                    end
                end
                RUN:     r_state <= RUN;
                default: r_state <= CLEAR;
            endcase
            r_rsp_valid <= w_accept;
            r_rsp_err   <= w_accept && w_err;
            r_rsp_rdata <= (w_accept && !bus.req_we && !w_err) ? w_load : '0;
        end
    end

    // Array writes: zero-clear during CLEAR, byte-lane stores during RUN.
    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == CLEAR)) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_store_go) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (r_state == RUN);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule : data_memory
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory
//  Description : Self-checking bench for data_memory (RV64 instance with a
//                scoreboard, plus an RV32 instance for size-error checks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;
    import mem_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_memory_if #(.DEPTH(32), .XLEN(64)) bus   ();
    data_memory_if #(.DEPTH(32), .XLEN(32)) bus32 ();

    data_memory #(.DEPTH(32), .XLEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    data_memory #(.DEPTH(32), .XLEN(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          due;
        string       tag;
    } exp_t;

    exp_t q[$];
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: an expected response must appear at the negedge right
    // after its accept edge; at every other negedge rsp_valid must be low.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            n_tests++;
            assert (bus.rsp_valid === 1'b1) else begin
                n_fail++;
                $error("FAIL %s valid: got %b want 1", e.tag, bus.rsp_valid);
            end
            n_tests++;
            assert (bus.rsp_rdata === e.rdata) else begin
                n_fail++;
                $error("FAIL %s rdata: got %h want %h", e.tag, bus.rsp_rdata, e.rdata);
            end
            n_tests++;
            assert (bus.rsp_err === e.err) else begin
                n_fail++;
                $error("FAIL %s err: got %b want %b", e.tag, bus.rsp_err, e.err);
            end
        end else begin
            n_tests++;
            assert (bus.rsp_valid === 1'b0) else begin
                n_fail++;
                $error("FAIL spurious_valid: got %b want 0 at cycle %0d", bus.rsp_valid, cyc);
            end
        end
    end

    // Present one request for one edge; expectation queued only if accepted
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] a,
                          input logic [63:0] wd, input logic [63:0] er, input logic ee,
                          input string tag);
        logic rdy;
        logic rs;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        rdy = bus.req_ready;
        rs  = rst_n;
        @(posedge clk);
        #1;
        if (rdy && rs) begin
            q.push_back('{er, ee, cyc, tag});
        end
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Count not-ready cycles following a reset release
    task automatic check_clear(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_tests++;
        assert (n == 32) else begin
            n_fail++;
            $error("FAIL %s clear_cycles: got %0d want 32", tag, n);
        end
    endtask

    // RV32 instance: single request, checked at the following negedge
    task automatic req32(input logic we, input logic [2:0] f3, input logic [6:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input string tag);
        bus32.req_valid  = 1'b1;
        bus32.req_we     = we;
        bus32.req_funct3 = f3;
        bus32.req_addr   = a;
        bus32.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus32.req_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        assert (bus32.rsp_valid === 1'b1) else begin
            n_fail++;
            $error("FAIL %s valid: got %b want 1", tag, bus32.rsp_valid);
        end
        n_tests++;
        assert (bus32.rsp_rdata === er) else begin
            n_fail++;
            $error("FAIL %s rdata: got %h want %h", tag, bus32.rsp_rdata, er);
        end
        n_tests++;
        assert (bus32.rsp_err === ee) else begin
            n_fail++;
            $error("FAIL %s err: got %b want %b", tag, bus32.rsp_err, ee);
        end
    endtask

    logic [31:0] b2b_val [4];

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_funct3   = 3'b000;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus32.req_valid  = 1'b0;
        bus32.req_we     = 1'b0;
        bus32.req_funct3 = 3'b000;
        bus32.req_addr   = '0;
        bus32.req_wdata  = '0;
        b2b_val[0] = 32'h1234_5678;
        b2b_val[1] = 32'h8765_4321;
        b2b_val[2] = 32'hDEAD_BEEF;
        b2b_val[3] = 32'h0000_7FFF;

        // 1. Reset held two cycles, then a full clear sweep
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        assert (bus.req_ready === 1'b0 && bus.rsp_valid === 1'b0 &&
                bus.rsp_rdata === 64'h0 && bus.rsp_err === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_outputs: got rdy=%b v=%b d=%h e=%b want all 0",
                   bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        rst_n = 1'b1;
        check_clear("first");
        for (int i = 0; i < 32; i++) begin
            do_req(1'b0, F3_D, 8'(i * 8), 64'h0, 64'h0, 1'b0, "ld_cleared");
        end
        idle();

        // Dirty two words, then reset with a request on the same edge:
        // no response may emerge and the sweep must re-zero the words.
        do_req(1'b1, F3_D, 8'h10, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 1'b0, "sd_dirty0");
        do_req(1'b1, F3_D, 8'hF8, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0, 1'b0, "sd_dirty1");
        idle();
        rst_n = 1'b0;
        do_req(1'b0, F3_D, 8'h10, 64'h0, 64'h0, 1'b0, "ld_in_reset");
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        check_clear("run_reset");
        do_req(1'b0, F3_D, 8'h10, 64'h0, 64'h0, 1'b0, "ld_recleared0");
        do_req(1'b0, F3_D, 8'hF8, 64'h0, 64'h0, 1'b0, "ld_recleared1");
        idle();

        // Reset pulsed at clear cycle 10 restarts a full sweep
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_clear("mid_clear");

        // 2. Full-word round trip
        do_req(1'b1, F3_D, 8'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, "sd_10");
        do_req(1'b0, F3_D, 8'h10, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, "ld_10");

        // 3. Sub-word loads and extension
        do_req(1'b0, F3_B,  8'h10, 64'h0, 64'hFFFF_FFFF_FFFF_FFEF, 1'b0, "lb_10");
        do_req(1'b0, F3_BU, 8'h10, 64'h0, 64'h0000_0000_0000_00EF, 1'b0, "lbu_10");
        do_req(1'b0, F3_H,  8'h12, 64'h0, 64'hFFFF_FFFF_FFFF_89AB, 1'b0, "lh_12");
        do_req(1'b0, F3_HU, 8'h16, 64'h0, 64'h0000_0000_0000_0123, 1'b0, "lhu_16");
        do_req(1'b0, F3_W,  8'h14, 64'h0, 64'h0000_0000_0123_4567, 1'b0, "lw_14");
        do_req(1'b0, F3_W,  8'h10, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, "lw_10");
        do_req(1'b0, F3_WU, 8'h10, 64'h0, 64'h0000_0000_89AB_CDEF, 1'b0, "lwu_10");

        // 4. Byte-lane store; only byte 0 of wdata is used
        do_req(1'b1, F3_B, 8'h13, 64'hAAAA_AAAA_AAAA_AA55, 64'h0, 1'b0, "sb_13");
        do_req(1'b0, F3_D, 8'h10, 64'h0, 64'h0123_4567_55AB_CDEF, 1'b0, "ld_after_sb");
        do_req(1'b0, F3_D, 8'h08, 64'h0, 64'h0, 1'b0, "ld_08_untouched");
        do_req(1'b0, F3_D, 8'h18, 64'h0, 64'h0, 1'b0, "ld_18_untouched");

        // 5. Error cases; no array write may occur
        do_req(1'b0, F3_H,   8'h11, 64'h0, 64'h0, 1'b1, "lh_misalign");
        do_req(1'b1, F3_W,   8'h22, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, "sw_misalign");
        do_req(1'b1, F3_D,   8'h0C, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, "sd_misalign");
        do_req(1'b0, 3'b111, 8'h10, 64'h0, 64'h0, 1'b1, "ld_f3_111");
        do_req(1'b1, 3'b111, 8'h18, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, "st_f3_111");
        do_req(1'b1, F3_BU,  8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, "st_unsigned");
        do_req(1'b0, F3_D,   8'h10, 64'h0, 64'h0123_4567_55AB_CDEF, 1'b0, "ld_10_unchanged");
        do_req(1'b0, F3_D,   8'h20, 64'h0, 64'h0, 1'b0, "ld_20_unchanged");
        do_req(1'b0, F3_D,   8'h08, 64'h0, 64'h0, 1'b0, "ld_08_unchanged");
        do_req(1'b0, F3_D,   8'h18, 64'h0, 64'h0, 1'b0, "ld_18_unchanged");
        idle();

        // 6. Back-to-back SW/LW, valid held high for 8 cycles
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, F3_W, 8'h40, {32'hCAFE_F00D, b2b_val[i]}, 64'h0, 1'b0, "b2b_sw");
            do_req(1'b0, F3_W, 8'h40, 64'h0, {{32{b2b_val[i][31]}}, b2b_val[i]}, 1'b0, "b2b_lw");
        end
        do_req(1'b0, F3_D, 8'h40, 64'h0, 64'h0000_0000_0000_7FFF, 1'b0, "b2b_ld_upper");
        idle();

        // RV32 instance: D and WU are unsupported
        n_tests++;
        assert (bus32.req_ready === 1'b1) else begin
            n_fail++;
            $error("FAIL rv32_ready: got %b want 1", bus32.req_ready);
        end
        req32(1'b0, F3_D,  7'h00, 32'h0, 32'h0, 1'b1, "rv32_ld");
        req32(1'b0, F3_WU, 7'h00, 32'h0, 32'h0, 1'b1, "rv32_lwu");
        req32(1'b1, F3_D,  7'h00, 32'hFFFF_FFFF, 32'h0, 1'b1, "rv32_sd");
        req32(1'b1, F3_W,  7'h04, 32'h8000_0000, 32'h0, 1'b0, "rv32_sw");
        req32(1'b0, F3_W,  7'h04, 32'h0, 32'h8000_0000, 1'b0, "rv32_lw");
        req32(1'b0, F3_B,  7'h07, 32'h0, 32'hFFFF_FF80, 1'b0, "rv32_lb");
        req32(1'b0, F3_HU, 7'h06, 32'h0, 32'h0000_8000, 1'b0, "rv32_lhu");
        req32(1'b0, F3_W,  7'h00, 32'h0, 32'h0, 1'b0, "rv32_lw_sd_blocked");

        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL pending_responses: got %0d want 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_data_memory
`default_nettype wire
